dvp_tx_emulator: RTL and testbench
==================================

Name: dvp_tx_emulator

Overview:
- DVP (OV7670-style) camera transmitter. Drives pclk/vsync/href/data[7:0] exactly as the OV7670 does in RGB565 mode.
- Source is an internal test-pattern generator, plus an optional external pixel stream.
- Feeds the existing camera capture path in place of the sensor, for board bring-up and simulation of capture → buffer → VGA without a camera.

Parameters:
- H_ACTIVE, 640, active pixels per line (2 bytes each).
- H_BLANK, 288, blank byte-times after href falls, per line.
- V_ACTIVE, 480, active lines per frame.
- VSYNC_LINES, 3, lines with vsync high.
- V_BACK, 17, blank lines between vsync fall and first active line.
- V_FRONT, 10, blank lines after last active line.

Ports:
- clk  in  1  system clock; byte rate = clk/2.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run frames while high.
- pattern_sel  in  2  0 colour bars, 1 gradient, 2 solid, 3 checker.
- solid_color  in  16  RGB565 value for pattern 2.
- cam_pclk  out  1  generated pixel clock.
- cam_vsync  out  1  frame sync, active high.
- cam_href  out  1  line valid, active high.
- cam_data  out  8  byte data.
- busy  out  1  high from frame start to frame end.
- frame_done  out  1  one-clk pulse at end of frame.
- frame_cnt  out  8  completed frames, wraps.

Behaviour:
- Reset (async, immediate): cam_pclk, cam_vsync, cam_href, cam_data, busy, frame_done, frame_cnt all 0; FSM to IDLE.
- cam_pclk is a register toggling every clk from reset release (free-running, also in IDLE).
- Tick = the clk edge where cam_pclk goes 1→0. All FSM, counter and output changes happen only on ticks, so data is stable at the receiver's rising-pclk sample, half a byte period later.
- Line length LINE = 2*H_ACTIVE + H_BLANK ticks, counted by byte_cnt. line_cnt counts lines within the current state.
- FSM states:
  - IDLE: all outputs low. On a tick with enable=1, latch pattern_sel, go to VSYNC, busy=1.
  - VSYNC: cam_vsync=1 for VSYNC_LINES*LINE ticks, then go to VBACK.
  - VBACK: V_BACK lines, vsync=0, href=0, then go to ACTIVE.
  - ACTIVE: V_ACTIVE lines. cam_href=1 for the first 2*H_ACTIVE ticks of each line, then 0 for H_BLANK ticks. After the last line, go to VFRONT.
  - VFRONT: V_FRONT lines. On its final tick: frame_done=1 for one clk, frame_cnt+1 (255→0), busy=0.
  - Next state after VFRONT: VSYNC if enable=1 (pattern_sel re-latched, no idle gap), else IDLE.
- Enable deasserted mid-frame: the frame always completes; it is only checked at frame boundary.
- Byte order: high byte first. Byte 2k = pixel[15:8], byte 2k+1 = pixel[7:0], with x=k and y=active line index.
- cam_data = 0 whenever href=0.
- Patterns, computed on the high-byte tick and held for the low byte:
  - 0 (colour bars): bar = (x*8)/H_ACTIVE, mapping 0..7 → FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1 (gradient): {x[7:3], y[7:2], ~x[7:3]}.
  - 2 (solid): solid_color sampled per pixel.
  - 3 (checker): (x[5]^y[5]) ? FFFF : 0000.
- Parameter rule: all parameters ≥1; H_ACTIVE a multiple of 8.

Optional Feature:
- Macro: DVP_TX_EXT_PIXEL_EN.
- When defined:
  - Adds ports pix_data in 16, pix_valid in 1, pix_ready out 1, underflow out 1, and pattern_sel value 2 selects the external stream instead of solid.
  - pix_ready=1 for exactly the one clk of each high-byte tick in ACTIVE. Transfer occurs when pix_valid && pix_ready.
  - If pix_valid=0 at that tick: the pixel is sent as 0000 and underflow sets. underflow is sticky and cleared only at the next VSYNC entry or by reset.
- When undefined: the ports do not exist and pattern 2 is solid_color.

Test Plan (H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; LINE=20 ticks, frame=140 ticks=280 clks):
- Reset with enable=0 → all outputs 0, cam_pclk toggles every clk, state stays IDLE; assert rst_n low mid-frame → outputs 0 within the same clk, frame_cnt=0.
- enable=1, pattern 0 → vsync high 20 ticks; first href rise 40 ticks after vsync rise; 4 href pulses of 16 ticks, each followed by 4 low ticks; bytes of line 0 = FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
- Continuous enable → frame_done pulses every 280 clks, one clk wide; after 256 frames frame_cnt wraps to 0; no IDLE gap between frames.
- Drop enable during ACTIVE → frame completes, frame_done fires, then IDLE with busy=0; pattern_sel change mid-frame has no effect until next frame.
- Pattern 3 with H_ACTIVE=64 → x=31 gives 0000, x=32 gives FFFF on y=0; y=32 row inverted. Pattern 2 with solid_color=1234 → bytes 12,34 repeated.
- DVP_TX_EXT_PIXEL_EN: pix_valid held low for pixel 3 → bytes 00,00 at that slot, underflow=1 until next VSYNC entry; valid stream ABCD → bytes AB,CD.

Source files
------------

// File: rtl/dvp_tx_emulator.sv
// OV7670-style DVP transmitter (RGB565, high byte first) driven by an internal test-pattern generator.
// Define DVP_TX_EXT_PIXEL_EN to make pattern 2 pull pixels from an external valid/ready stream.
module dvp_tx_emulator #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 288,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
`ifdef DVP_TX_EXT_PIXEL_EN
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        underflow,
`endif
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
    localparam int BW    = $clog2(LINE + 1);
    localparam int MAX_A = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAXL  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LW    = $clog2(MAXL + 1);
    localparam int BAR_W = H_ACTIVE / 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [2:0]    state, nxt_state;
    logic [BW-1:0] byte_cnt, nxt_byte;
    logic [LW-1:0] line_cnt, nxt_line, lines_in_state;
    logic [1:0]    pat;
    logic [7:0]    pix_lo;
    logic          tick, frame_end, href_next, hi_byte, vsync_entry;
    logic [BW-1:0] x;
    logic [2:0]    bar;
    logic [15:0]   pixel;

    // cam_pclk is 1 during the clk that ends in its falling edge, which is the tick
    assign tick = cam_pclk;

    always_comb begin
        case (state)
            S_VSYNC:  lines_in_state = LW'(VSYNC_LINES);
            S_VBACK:  lines_in_state = LW'(V_BACK);
            S_ACTIVE: lines_in_state = LW'(V_ACTIVE);
            default:  lines_in_state = LW'(V_FRONT);
        endcase
    end

    always_comb begin
        nxt_state = state;
        nxt_byte  = byte_cnt;
        nxt_line  = line_cnt;
        frame_end = 1'b0;
        if (state == S_IDLE) begin
            if (enable) nxt_state = S_VSYNC;
            nxt_byte = '0;
            nxt_line = '0;
        end else if (byte_cnt != BW'(LINE - 1)) begin
            nxt_byte = byte_cnt + 1'b1;
        end else begin
            nxt_byte = '0;
            if (line_cnt != lines_in_state - 1'b1) begin
                nxt_line = line_cnt + 1'b1;
            end else begin
                nxt_line = '0;
                case (state)
                    S_VSYNC:  nxt_state = S_VBACK;
                    S_VBACK:  nxt_state = S_ACTIVE;
                    S_ACTIVE: nxt_state = S_VFRONT;
                    default: begin
                        frame_end = 1'b1;
                        nxt_state = enable ? S_VSYNC : S_IDLE;
                    end
                endcase
            end
        end
    end

    // Outputs are registered from the slot being entered, so x/y come from the next counters
    assign href_next   = (nxt_state == S_ACTIVE) && (nxt_byte < BW'(2 * H_ACTIVE));
    assign hi_byte     = href_next && !nxt_byte[0];
    assign x           = nxt_byte >> 1;
    assign bar         = 3'(x / BW'(BAR_W));
    assign vsync_entry = (state != S_VSYNC) && (nxt_state == S_VSYNC);

`ifdef DVP_TX_EXT_PIXEL_EN
    assign pix_ready = tick && hi_byte && (pat == 2'd2);
`endif

    always_comb begin
        pixel = 16'h0000;
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0: pixel = 16'hFFFF;
                    3'd1: pixel = 16'hFFE0;
                    3'd2: pixel = 16'h07FF;
                    3'd3: pixel = 16'h07E0;
                    3'd4: pixel = 16'hF81F;
                    3'd5: pixel = 16'hF800;
                    3'd6: pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1: pixel = {5'(x >> 3), 6'(nxt_line >> 2), ~5'(x >> 3)};
`ifdef DVP_TX_EXT_PIXEL_EN
            2'd2: pixel = pix_valid ? pix_data : 16'h0000;
`else
            2'd2: pixel = solid_color;
`endif
            default: pixel = (1'(x >> 5) ^ 1'(nxt_line >> 5)) ? 16'hFFFF : 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam_pclk   <= 1'b0;
            cam_vsync  <= 1'b0;
            cam_href   <= 1'b0;
            cam_data   <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'h00;
            state      <= S_IDLE;
            byte_cnt   <= '0;
            line_cnt   <= '0;
            pat        <= 2'd0;
            pix_lo     <= 8'h00;
`ifdef DVP_TX_EXT_PIXEL_EN
            underflow  <= 1'b0;
`endif
        end else begin
            cam_pclk   <= ~cam_pclk;
            frame_done <= 1'b0;
            if (tick) begin
                state     <= nxt_state;
                byte_cnt  <= nxt_byte;
                line_cnt  <= nxt_line;
                cam_vsync <= (nxt_state == S_VSYNC);
                cam_href  <= href_next;
                busy      <= (nxt_state != S_IDLE);
                if (vsync_entry) pat <= pattern_sel;
                if (frame_end) begin
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 1'b1;
                end
                if (hi_byte) begin
                    cam_data <= pixel[15:8];
                    pix_lo   <= pixel[7:0];
                end else if (href_next) begin
                    cam_data <= pix_lo;
                end else begin
                    cam_data <= 8'h00;
                end
`ifdef DVP_TX_EXT_PIXEL_EN
                if (vsync_entry) underflow <= 1'b0;
                else if (pix_ready && !pix_valid) underflow <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_dvp_tx_emulator.sv
// Scoreboard bench for dvp_tx_emulator: stimulus queues expected bytes, monitors pop and compare.
// A second instance (H_ACTIVE=64) checks the checker pattern at its bit-5 boundaries.
module tb_dvp_tx_emulator;

    logic        clk, rst_n, enable, en2;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        cam_pclk, cam_vsync, cam_href, busy, frame_done;
    logic [7:0]  cam_data, frame_cnt;
    logic        pclk2, vsync2, href2, busy2, done2;
    logic [7:0]  data2, cnt2;
`ifdef DVP_TX_EXT_PIXEL_EN
    logic [15:0] pix_data;
    logic        pix_valid, pix_ready, underflow;
    logic        pix_ready2, underflow2;
    int          rdy_seen;
`endif

    typedef struct {
        int         line;
        int         pos;
        logic [7:0] val;
    } chk_t;

    localparam logic [7:0] BAR_BYTES [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                              8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    int         checks = 0;
    int         errors = 0;
    int         epoch = 0;
    logic [7:0] exp_q[$];
    chk_t       chk_q[$];
    bit         chk_finished = 0;

    dvp_tx_emulator #(
        .H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel), .solid_color(solid_color),
`ifdef DVP_TX_EXT_PIXEL_EN
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .underflow(underflow),
`endif
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    dvp_tx_emulator #(
        .H_ACTIVE(64), .H_BLANK(4), .V_ACTIVE(33), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut_chk (
        .clk(clk), .rst_n(rst_n), .enable(en2), .pattern_sel(2'd3), .solid_color(16'h0000),
`ifdef DVP_TX_EXT_PIXEL_EN
        .pix_data(16'h0000), .pix_valid(1'b0), .pix_ready(pix_ready2), .underflow(underflow2),
`endif
        .cam_pclk(pclk2), .cam_vsync(vsync2), .cam_href(href2), .cam_data(data2),
        .busy(busy2), .frame_done(done2), .frame_cnt(cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] pat, input logic [15:0] solid);
        enable      = en;
        pattern_sel = pat;
        solid_color = solid;
    endtask

    task automatic pushBars();
        for (int y = 0; y < 4; y++)
            for (int i = 0; i < 16; i++) exp_q.push_back(BAR_BYTES[i]);
    endtask

    task automatic pushPairs(input logic [7:0] hi, input logic [7:0] lo);
        for (int k = 0; k < 32; k++) begin
            exp_q.push_back(hi);
            exp_q.push_back(lo);
        end
    endtask

    task automatic waitFrameDone(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 400);
        if (!frame_done) checkOutput({name, " frame_done timeout"}, 0, 1);
    endtask

    task automatic waitSignal(input string name, input bit use_href);
        int n = 0;
        while ((use_href ? cam_href : busy) !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " reached"}, use_href ? cam_href : busy, 1);
    endtask

`ifdef DVP_TX_EXT_PIXEL_EN
    // Pixel 3 of the external-stream frame is withheld to provoke an underflow
    initial begin
        pix_data  = 16'hABCD;
        pix_valid = 1'b1;
        rdy_seen  = 0;
        forever begin
            @(negedge clk);
            if (pix_ready) begin
                pix_valid = (rdy_seen != 3);
                rdy_seen++;
            end
        end
    end
`endif

    int         cyc = 0, last_done = 0, seen_epoch = 0;
    bit         period_ok = 0, first_href = 0;
    logic       prev_vsync = 0, prev_href = 0, prev_done = 0;
    int         vs_run = 0, href_run = 0, low_run = 0, since_vs = 0, pulses = 0;
    logic [7:0] exp_cnt = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (epoch != seen_epoch) begin
            period_ok  = 0;
            seen_epoch = epoch;
        end
        if (!rst_n) begin
            prev_vsync = 0; prev_href = 0; prev_done = 0;
            exp_cnt = 0; period_ok = 0; first_href = 0; pulses = 0;
        end else begin
            if (prev_done) checkOutput("frame_done width", frame_done, 0);
            if (frame_done) begin
                exp_cnt = exp_cnt + 8'd1;
                checkOutput("frame_cnt", frame_cnt, exp_cnt);
                checkOutput("href pulses per frame", pulses, 4);
                if (period_ok) checkOutput("frame period clks", cyc - last_done, 280);
                last_done = cyc;
                period_ok = 1;
            end
            prev_done = frame_done;
            if (cam_pclk) begin
                if (cam_vsync && !prev_vsync) begin
                    since_vs = 0; first_href = 1; pulses = 0; vs_run = 0;
                end
                if (cam_vsync) vs_run++;
                else if (prev_vsync) checkOutput("vsync length", vs_run, 20);
                if (cam_href && !prev_href) begin
                    if (first_href) checkOutput("vsync to href", since_vs, 40);
                    else checkOutput("hblank length", low_run, 4);
                    first_href = 0;
                    pulses++;
                    href_run = 0;
                end
                if (cam_href) begin
                    href_run++;
                    if (exp_q.size() == 0) checkOutput("scoreboard has byte", 0, 1);
                    else checkOutput("pixel byte", cam_data, exp_q.pop_front());
                end else begin
                    if (prev_href) begin
                        checkOutput("href length", href_run, 16);
                        low_run = 0;
                    end
                    low_run++;
                    checkOutput("data zero in blank", cam_data, 0);
                end
                since_vs++;
                prev_vsync = cam_vsync;
                prev_href  = cam_href;
            end
        end
    end

    int   line2 = 0, pos2 = 0;
    logic pv2 = 0, ph2 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done2) begin
                checkOutput("checker points seen", chk_q.size(), 0);
                chk_finished = 1;
            end
            if (pclk2) begin
                if (vsync2 && !pv2) line2 = -1;
                if (href2 && !ph2) begin
                    line2++;
                    pos2 = 0;
                end
                if (href2) begin
                    if (chk_q.size() > 0 && chk_q[0].line == line2 && chk_q[0].pos == pos2)
                        checkOutput("checker byte", data2, chk_q.pop_front().val);
                    pos2++;
                end
                pv2 = vsync2;
                ph2 = href2;
            end
        end
    end

    initial begin
        int n;
        en2 = 1'b0;
        @(posedge rst_n);
        chk_q.push_back('{0, 62, 8'h00});
        chk_q.push_back('{0, 63, 8'h00});
        chk_q.push_back('{0, 64, 8'hFF});
        chk_q.push_back('{0, 65, 8'hFF});
        chk_q.push_back('{32, 62, 8'hFF});
        chk_q.push_back('{32, 63, 8'hFF});
        chk_q.push_back('{32, 64, 8'h00});
        chk_q.push_back('{32, 65, 8'h00});
        @(negedge clk);
        en2 = 1'b1;
        n = 0;
        while (!busy2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        en2 = 1'b0;
    end

    initial begin
        logic prev;
        int   n;
        rst_n = 1'b0;
        applyStimulus(0, 0, 16'h0000);
        repeat (3) @(negedge clk);
        checkOutput("reset cam_pclk", cam_pclk, 0);
        checkOutput("reset cam_vsync", cam_vsync, 0);
        checkOutput("reset cam_href", cam_href, 0);
        checkOutput("reset cam_data", cam_data, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset frame_done", frame_done, 0);
        checkOutput("reset frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        prev  = cam_pclk;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("pclk toggle in idle", cam_pclk, !prev);
            prev = cam_pclk;
        end
        repeat (20) @(negedge clk);
        checkOutput("idle busy", busy, 0);
        checkOutput("idle vsync", cam_vsync, 0);

        // Three back-to-back frames; pattern changes mid-frame only apply to the next one
        pushBars();
        epoch++;
        applyStimulus(1, 0, 16'h1234);
        waitSignal("busy", 0);
        repeat (10) @(negedge clk);
        applyStimulus(1, 1, 16'h1234);
        pushPairs(8'h00, 8'h1F);
        waitFrameDone("frame A");
        checkOutput("busy across frames", busy, 1);
        repeat (50) @(negedge clk);
        applyStimulus(1, 2, 16'h1234);
`ifdef DVP_TX_EXT_PIXEL_EN
        for (int k = 0; k < 32; k++) begin
            exp_q.push_back(k == 3 ? 8'h00 : 8'hAB);
            exp_q.push_back(k == 3 ? 8'h00 : 8'hCD);
        end
`else
        pushPairs(8'h12, 8'h34);
`endif
        waitFrameDone("frame B");
        waitSignal("href", 1);
        applyStimulus(0, 2, 16'h1234);
        waitFrameDone("frame C");
        checkOutput("busy after last frame", busy, 0);
        checkOutput("frame_cnt after 3", frame_cnt, 3);
        repeat (20) @(negedge clk);
        checkOutput("idle after disable busy", busy, 0);
        checkOutput("idle after disable vsync", cam_vsync, 0);
        checkOutput("scoreboard drained", exp_q.size(), 0);
`ifdef DVP_TX_EXT_PIXEL_EN
        checkOutput("underflow sticky", underflow, 1);
`endif

        // Free-running until frame_cnt wraps from 255 to 0
        pushBars();
        epoch++;
        applyStimulus(1, 0, 16'h1234);
        waitSignal("busy", 0);
`ifdef DVP_TX_EXT_PIXEL_EN
        checkOutput("underflow cleared at vsync", underflow, 0);
`endif
        for (int f = 0; f < 253; f++) begin
            waitFrameDone("continuous");
            checkOutput("no idle gap", busy, 1);
            pushBars();
        end
        checkOutput("frame_cnt wrap", frame_cnt, 0);

        repeat (100) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset vsync", cam_vsync, 0);
        checkOutput("async reset href", cam_href, 0);
        checkOutput("async reset data", cam_data, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset pclk", cam_pclk, 0);
        checkOutput("async reset frame_cnt", frame_cnt, 0);
        exp_q.delete();
        applyStimulus(0, 0, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("idle after reset busy", busy, 0);

        n = 0;
        while (!chk_finished && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("checker frame finished", chk_finished, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
